// File: rtl/bsram_loader_if.sv
// Control, byte-stream and RAM write-port bundle for bsram_loader.
// The checksum signal exists only when BSRAM_LOADER_CHECKSUM_EN is defined.
interface bsram_loader_if #(
    parameter int WIDTH = 13
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] base_addr;
    logic [WIDTH:0]   word_count;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             we;
    logic [WIDTH-1:0] mem_din_addr;
    logic [15:0]      mem_din;
    logic             busy;
    logic             done;
`ifdef BSRAM_LOADER_CHECKSUM_EN
    logic [15:0]      checksum;
`endif

    modport master (
        output start, abort, base_addr, word_count, in_valid, in_data,
        input  in_ready, we, mem_din_addr, mem_din, busy, done
`ifdef BSRAM_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, abort, base_addr, word_count, in_valid, in_data,
        output in_ready, we, mem_din_addr, mem_din, busy, done
`ifdef BSRAM_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/bsram_loader.sv
// Packs a byte stream (low byte first) into 16-bit words written to consecutive RAM addresses.
// Define BSRAM_LOADER_CHECKSUM_EN to add a running 16-bit sum of all written words.
module bsram_loader #(
    parameter int WIDTH = 13
) (
    input  logic          clk,
    input  logic          reset,
    bsram_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, WRITE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic [WIDTH:0]   remain_reg, remain_next;
    logic [7:0]       lo_reg, lo_next;
    logic             we_reg, we_next;
    logic [WIDTH-1:0] din_addr_reg, din_addr_next;
    logic [15:0]      din_reg, din_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             in_ready;
    logic             accept;
`ifdef BSRAM_LOADER_CHECKSUM_EN
    logic [15:0]      cksum_reg, cksum_next;
`endif

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready = (state_reg == LO) || (state_reg == HI);
    assign accept   = in_ready && bus.in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            remain_reg   <= '0;
            lo_reg       <= '0;
            we_reg       <= 1'b0;
            din_addr_reg <= '0;
            din_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef BSRAM_LOADER_CHECKSUM_EN
            cksum_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            remain_reg   <= remain_next;
            lo_reg       <= lo_next;
            we_reg       <= we_next;
            din_addr_reg <= din_addr_next;
            din_reg      <= din_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
`ifdef BSRAM_LOADER_CHECKSUM_EN
            cksum_reg    <= cksum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        remain_next   = remain_reg;
        lo_next       = lo_reg;
        we_next       = 1'b0;
        din_addr_next = din_addr_reg;
        din_next      = din_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
`ifdef BSRAM_LOADER_CHECKSUM_EN
        cksum_next    = cksum_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A zero-length load stays in IDLE: busy and done both show for one cycle.
                busy_next = bus.start;
                if (bus.start) begin
                    addr_next   = bus.base_addr;
                    remain_next = bus.word_count;
`ifdef BSRAM_LOADER_CHECKSUM_EN
                    cksum_next  = '0;
`endif
                    if (bus.word_count == '0) done_next = 1'b1;
                    else                      state_next = LO;
                end
            end
            LO: begin
                if (accept) begin
                    lo_next    = bus.in_data;
                    state_next = HI;
                end
            end
            HI: begin
                if (accept) begin
                    din_next      = {bus.in_data, lo_reg};
                    din_addr_next = addr_reg;
                    we_next       = 1'b1;
                    state_next    = WRITE;
                end
            end
            WRITE: begin
                addr_next   = addr_reg + WIDTH'(1);
                remain_next = remain_reg - (WIDTH + 1)'(1);
`ifdef BSRAM_LOADER_CHECKSUM_EN
                cksum_next  = cksum_reg + din_reg;
`endif
                if (remain_reg == (WIDTH + 1)'(1)) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    state_next = LO;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides accepts; a write already on the bus (WRITE state) still finishes.
        if (bus.abort && (state_reg != IDLE)) begin
            state_next    = IDLE;
            busy_next     = 1'b0;
            done_next     = 1'b0;
            we_next       = 1'b0;
            din_next      = din_reg;
            din_addr_next = din_addr_reg;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.we           = we_reg;
    assign bus.mem_din_addr = din_addr_reg;
    assign bus.mem_din      = din_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
`ifdef BSRAM_LOADER_CHECKSUM_EN
    assign bus.checksum     = cksum_reg;
`endif
endmodule

// File: tb/tb_bsram_loader.sv
// Directed bench for bsram_loader: table of load vectors plus abort and async-reset sequences.
module tb_bsram_loader;
    localparam int WIDTH = 13;

    logic clk;
    logic reset;

    bsram_loader_if #(.WIDTH(WIDTH)) bus ();

    bsram_loader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0]       base;
        logic [13:0]       count;
        logic              gated;
        logic              poke;
        logic [7:0][7:0]   bytes;
        logic [3:0][15:0]  exp_data;
        logic [3:0][12:0]  exp_addr;
        logic [15:0]       exp_cks;
    } vec_t;

    vec_t vecs [5];

    int total = 0;
    int bad   = 0;

    logic [12:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int done_cnt = 0;
    int busy_cnt = 0;
    int rdy_cnt  = 0;

    // Observe the DUT on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.we) begin
            wq_addr.push_back(bus.mem_din_addr);
            wq_data.push_back(bus.mem_din);
        end
        if (bus.done)     done_cnt++;
        if (bus.busy)     busy_cnt++;
        if (bus.in_ready) rdy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [63:0] pack4d(input logic [15:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [51:0] pack4a(input logic [12:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic start_load(input logic [12:0] base, input logic [13:0] cnt);
        @(negedge clk);
        bus.base_addr  = base;
        bus.word_count = cnt;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.base_addr  = 13'h1555;
        bus.word_count = 14'h0003;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Offers nbytes bytes; returns at the falling edge after the last one was accepted.
    task automatic feed(input logic [63:0] bytes, input int nbytes, input bit gated, input bit poke);
        int  k      = 0;
        int  guard  = 0;
        bit  poked  = 1'b0;
        bit  v;
        bit  acc;
        while (k < nbytes && guard < 400) begin
            v = gated ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = bytes[k*8 +: 8];
            if (poke && k == 3 && !poked) begin
                bus.start      = 1'b1;
                bus.base_addr  = 13'h0777;
                bus.word_count = 14'd1;
                poked          = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            acc = v && bus.in_ready;
            @(negedge clk);
            if (acc) k++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (guard >= 400) check("feed_timeout", 32'(k), 32'(nbytes));
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int wi, dn, bz, rd, n;

        vecs[0].base = 13'h0010; vecs[0].count = 14'd2; vecs[0].gated = 0; vecs[0].poke = 0;
        vecs[0].bytes    = pack8(8'h34, 8'h12, 8'h78, 8'h56, 0, 0, 0, 0);
        vecs[0].exp_data = pack4d(16'h1234, 16'h5678, 0, 0);
        vecs[0].exp_addr = pack4a(13'h0010, 13'h0011, 0, 0);
        vecs[0].exp_cks  = 16'h68AC;

        vecs[1].base = 13'h1FFF; vecs[1].count = 14'd2; vecs[1].gated = 0; vecs[1].poke = 0;
        vecs[1].bytes    = pack8(8'h01, 8'h00, 8'h02, 8'h00, 0, 0, 0, 0);
        vecs[1].exp_data = pack4d(16'h0001, 16'h0002, 0, 0);
        vecs[1].exp_addr = pack4a(13'h1FFF, 13'h0000, 0, 0);
        vecs[1].exp_cks  = 16'h0003;

        vecs[2].base = 13'h0100; vecs[2].count = 14'd4; vecs[2].gated = 0; vecs[2].poke = 0;
        vecs[2].bytes    = pack8(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88);
        vecs[2].exp_data = pack4d(16'h2211, 16'h4433, 16'h6655, 16'h8877);
        vecs[2].exp_addr = pack4a(13'h0100, 13'h0101, 13'h0102, 13'h0103);
        vecs[2].exp_cks  = 16'h5510;

        vecs[3] = vecs[2];
        vecs[3].gated = 1; vecs[3].poke = 1;

        vecs[4].base = 13'h0AAA; vecs[4].count = 14'd0; vecs[4].gated = 0; vecs[4].poke = 0;
        vecs[4].bytes    = '0;
        vecs[4].exp_data = '0;
        vecs[4].exp_addr = '0;
        vecs[4].exp_cks  = 16'h0000;

        bus.start = 0; bus.abort = 0; bus.base_addr = '0; bus.word_count = '0;
        bus.in_valid = 0; bus.in_data = '0;
        reset = 1'b1;
        settle(3);
        check("rst_we",       {31'd0, bus.we},       0);
        check("rst_busy",     {31'd0, bus.busy},     0);
        check("rst_done",     {31'd0, bus.done},     0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 0);
        check("rst_addr",     32'(bus.mem_din_addr), 0);
        check("rst_din",      32'(bus.mem_din),      0);
`ifdef BSRAM_LOADER_CHECKSUM_EN
        check("rst_cks",      32'(bus.checksum),     0);
`endif
        reset = 1'b0;
        settle(2);

        for (int i = 0; i < 5; i++) begin
            wi = wq_addr.size(); dn = done_cnt; bz = busy_cnt; rd = rdy_cnt;
            start_load(vecs[i].base, vecs[i].count);
            feed(vecs[i].bytes, 2 * int'(vecs[i].count), vecs[i].gated, vecs[i].poke);
            settle(6);
            n = wq_addr.size() - wi;
            $display("vec %0d: base=%h count=%0d writes=%0d done=%0d", i, vecs[i].base,
                     vecs[i].count, n, done_cnt - dn);
            check($sformatf("v%0d_writes", i), 32'(n), 32'(vecs[i].count));
            check($sformatf("v%0d_done", i), 32'(done_cnt - dn), 1);
            for (int j = 0; j < int'(vecs[i].count) && j < n; j++) begin
                check($sformatf("v%0d_addr%0d", i, j), 32'(wq_addr[wi+j]), 32'(vecs[i].exp_addr[j]));
                check($sformatf("v%0d_data%0d", i, j), 32'(wq_data[wi+j]), 32'(vecs[i].exp_data[j]));
            end
            if (vecs[i].count == 0) begin
                check("zero_busy_cycles", 32'(busy_cnt - bz), 1);
                check("zero_in_ready",    32'(rdy_cnt - rd),  0);
            end
`ifdef BSRAM_LOADER_CHECKSUM_EN
            check($sformatf("v%0d_cks", i), 32'(bus.checksum), 32'(vecs[i].exp_cks));
`endif
            check($sformatf("v%0d_idle_busy", i), {31'd0, bus.busy}, 0);
        end

        // Abort while holding the low byte of word 1; the offered high byte must be dropped.
        wi = wq_addr.size(); dn = done_cnt;
        start_load(13'h0200, 14'd3);
        feed(pack8(8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0, 0), 3, 1'b0, 1'b0);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hDD;
        @(negedge clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_busy",     {31'd0, bus.busy},     0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 0);
        settle(4);
        n = wq_addr.size() - wi;
        $display("abort: writes=%0d done=%0d", n, done_cnt - dn);
        check("abort_writes", 32'(n), 1);
        if (n >= 1) begin
            check("abort_w0_addr", 32'(wq_addr[wi]), 32'h0200);
            check("abort_w0_data", 32'(wq_data[wi]), 32'hBBAA);
        end
        check("abort_done", 32'(done_cnt - dn), 0);

        wi = wq_addr.size(); dn = done_cnt;
        start_load(13'h0300, 14'd1);
        feed(pack8(8'h01, 8'h02, 0, 0, 0, 0, 0, 0), 2, 1'b0, 1'b0);
        settle(4);
        n = wq_addr.size() - wi;
        $display("after abort: writes=%0d done=%0d", n, done_cnt - dn);
        check("reload_writes", 32'(n), 1);
        if (n >= 1) begin
            check("reload_addr", 32'(wq_addr[wi]), 32'h0300);
            check("reload_data", 32'(wq_data[wi]), 32'h0201);
        end
        check("reload_done", 32'(done_cnt - dn), 1);
`ifdef BSRAM_LOADER_CHECKSUM_EN
        check("reload_cks", 32'(bus.checksum), 32'h0201);
`endif

        // Asynchronous reset mid-cycle while waiting for the high byte.
        start_load(13'h0400, 14'd2);
        feed(pack8(8'h55, 0, 0, 0, 0, 0, 0, 0), 1, 1'b0, 1'b0);
        wi = wq_addr.size(); dn = done_cnt;
        bus.in_valid = 1'b1; bus.in_data = 8'h66;
        #2 reset = 1'b1;
        #1;
        check("async_in_ready", {31'd0, bus.in_ready}, 0);
        check("async_busy",     {31'd0, bus.busy},     0);
        check("async_we",       {31'd0, bus.we},       0);
        settle(2);
        reset = 1'b0; bus.in_valid = 1'b0;
        settle(4);
        n = wq_addr.size() - wi;
        $display("reset mid-load: writes=%0d done=%0d", n, done_cnt - dn);
        check("rst_mid_writes", 32'(n), 0);
        check("rst_mid_done",   32'(done_cnt - dn), 0);
        check("rst_mid_addr",   32'(bus.mem_din_addr), 0);
        check("rst_mid_din",    32'(bus.mem_din), 0);
        check("rst_mid_busy",   {31'd0, bus.busy}, 0);
`ifdef BSRAM_LOADER_CHECKSUM_EN
        check("rst_mid_cks",    32'(bus.checksum), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
